// File: rtl/unidade_mult_div.sv
// Iterative multiply/divide unit: one bit per cycle, result returned through the register bank write port.
// Optional build macro MULTDIV_SIGNED_EN reinterprets ops 01/10/11 as MULH/DIV/REM (signed).
module unidade_mult_div #(
  parameter int LARGURA = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inicio,
  input  logic [1:0]         op,
  input  logic [LARGURA-1:0] operando_a,
  input  logic [LARGURA-1:0] operando_b,
  input  logic [4:0]         destino_in,
  output logic               ocupado,
  output logic               escrita,
  output logic [4:0]         destino,
  output logic [LARGURA-1:0] dado_saida
);

  localparam int CW = $clog2(LARGURA + 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CALCULA = 2'b01,
    ESCREVE = 2'b10
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [CW-1:0]      cont_q, cont_d;
  logic [1:0]         op_q, op_d;
  logic [LARGURA-1:0] opnd_q, opnd_d;
  logic [LARGURA-1:0] hi_q, hi_d;
  logic [LARGURA-1:0] lo_q, lo_d;
  logic [4:0]         destino_q, destino_d;
  logic [LARGURA-1:0] saida_q, saida_d;

  // hi/lo are shared: product {hi,lo} for multiply, {remainder,quotient} for divide.
  logic [LARGURA:0]   soma;
  logic [LARGURA:0]   desl;
  logic [LARGURA+1:0] dif;
  logic               borrow;
  logic [LARGURA-1:0] passo_hi, passo_lo;
  logic [LARGURA-1:0] resultado;
  logic [LARGURA-1:0] a_abs, b_abs;

  assign soma     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {LARGURA{1'b0}})};
  assign desl     = {hi_q, lo_q[LARGURA-1]};
  assign dif      = {1'b0, desl} - {2'b00, opnd_q};
  assign borrow   = dif[LARGURA+1];
  assign passo_hi = op_q[1] ? (borrow ? desl[LARGURA-1:0] : dif[LARGURA-1:0])
                            : soma[LARGURA:1];
  assign passo_lo = op_q[1] ? {lo_q[LARGURA-2:0], ~borrow}
                            : {soma[0], lo_q[LARGURA-1:1]};

`ifdef MULTDIV_SIGNED_EN
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 sinal_a, sinal_b;
  logic [2*LARGURA-1:0] prod, prod_f;
  logic [LARGURA-1:0]   quo_f, rem_f;

  assign sinal_a = operando_a[LARGURA-1] & (op != 2'b00);
  assign sinal_b = operando_b[LARGURA-1] & (op != 2'b00);
  assign a_abs   = sinal_a ? -operando_a : operando_a;
  assign b_abs   = sinal_b ? -operando_b : operando_b;
  // A zero divisor leaves the quotient unsigned (all ones == -1).
  assign neg_d     = inicio && estado_q == OCIOSO
                     ? (op[1] ? ((sinal_a ^ sinal_b) & (operando_b != '0)) : (sinal_a ^ sinal_b))
                     : neg_q;
  assign neg_rem_d = inicio && estado_q == OCIOSO ? sinal_a : neg_rem_q;

  assign prod      = {passo_hi, passo_lo};
  assign prod_f    = neg_q ? -prod : prod;
  assign quo_f     = neg_q ? -passo_lo : passo_lo;
  assign rem_f     = neg_rem_q ? -passo_hi : passo_hi;
  assign resultado = op_q[1] ? (op_q[0] ? rem_f : quo_f)
                             : (op_q[0] ? prod_f[2*LARGURA-1:LARGURA] : prod_f[LARGURA-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  assign a_abs     = operando_a;
  assign b_abs     = operando_b;
  assign resultado = op_q[0] ? passo_hi : passo_lo;
`endif

  always_comb begin
    estado_d  = estado_q;
    cont_d    = cont_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    destino_d = destino_q;
    saida_d   = saida_q;
    unique case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          estado_d  = CALCULA;
          cont_d    = CW'(LARGURA);
          op_d      = op;
          destino_d = destino_in;
          hi_d      = '0;
          if (op[1]) begin
            lo_d   = a_abs;
            opnd_d = b_abs;
          end else begin
            lo_d   = b_abs;
            opnd_d = a_abs;
          end
        end
      end
      CALCULA: begin
        hi_d   = passo_hi;
        lo_d   = passo_lo;
        cont_d = cont_q - CW'(1);
        if (cont_q == CW'(1)) begin
          estado_d = ESCREVE;
          // Register 0 is never written, so the held output only changes on a real write.
          if (destino_q != 5'd0) saida_d = resultado;
        end
      end
      ESCREVE: estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= OCIOSO;
      cont_q    <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      destino_q <= '0;
      saida_q   <= '0;
    end else begin
      estado_q  <= estado_d;
      cont_q    <= cont_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      destino_q <= destino_d;
      saida_q   <= saida_d;
    end
  end

  assign ocupado    = (estado_q != OCIOSO);
  assign escrita    = (estado_q == ESCREVE) && (destino_q != 5'd0);
  assign destino    = destino_q;
  assign dado_saida = saida_q;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Directed bench for unidade_mult_div: vector table plus hand-written ignore/reset sequences.
module tb_unidade_mult_div;

  logic        clk;
  logic        rst_n;
  logic        inicio;
  logic [1:0]  op;
  logic [31:0] operando_a;
  logic [31:0] operando_b;
  logic [4:0]  destino_in;
  logic        ocupado;
  logic        escrita;
  logic [4:0]  destino;
  logic [31:0] dado_saida;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] prev_data = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  unidade_mult_div #(.LARGURA(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inicio     (inicio),
    .op         (op),
    .operando_a (operando_a),
    .operando_b (operando_b),
    .destino_in (destino_in),
    .ocupado    (ocupado),
    .escrita    (escrita),
    .destino    (destino),
    .dado_saida (dado_saida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts one op, watches 40 cycles; optional inicio pokes at cycles poke_a/poke_b must be ignored.
  task automatic run_op(input string name, input logic [1:0] op_v, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp_data,
                        input int poke_a, input int poke_b);
    int busy_n, first_busy, last_busy, wr_n, wr_k;
    logic [31:0] wr_data;
    logic [4:0]  wr_dest;
    logic [31:0] exp_hold;
    busy_n = 0; first_busy = 0; last_busy = 0; wr_n = 0; wr_k = 0;
    wr_data = '0; wr_dest = '0;
    @(negedge clk);
    inicio = 1'b1; op = op_v; operando_a = a; operando_b = b; destino_in = d;
    @(negedge clk);
    for (int k = 1; k <= 40; k++) begin
      if (ocupado) begin
        busy_n++;
        if (first_busy == 0) first_busy = k;
        last_busy = k;
      end
      if (escrita) begin
        wr_n++; wr_k = k; wr_data = dado_saida; wr_dest = destino;
      end
      if (k == poke_a || k == poke_b) begin
        inicio = 1'b1; op = 2'b10; operando_a = 32'd1; operando_b = 32'd1; destino_in = 5'd7;
      end else begin
        inicio = 1'b0;
      end
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 32'(busy_n), 32'd33);
    check({name, " first_busy"}, 32'(first_busy), 32'd1);
    check({name, " last_busy"}, 32'(last_busy), 32'd33);
    check({name, " write_count"}, 32'(wr_n), (d != 5'd0) ? 32'd1 : 32'd0);
    exp_hold = (d != 5'd0) ? exp_data : prev_data;
    if (d != 5'd0) begin
      check({name, " write_cycle"}, 32'(wr_k), 32'd33);
      check({name, " write_data"}, wr_data, exp_data);
      check({name, " write_dest"}, {27'd0, wr_dest}, {27'd0, d});
    end
    check({name, " data_hold"}, dado_saida, exp_hold);
    prev_data = exp_hold;
  endtask

  initial begin
    rst_n = 1'b0; inicio = 1'b0; op = '0; operando_a = '0; operando_b = '0; destino_in = '0;

`ifdef MULTDIV_SIGNED_EN
    tbl.push_back('{2'b00, 32'd5,        32'd10,       5'd3,  32'd50});
    tbl.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000001});
    tbl.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000});
    tbl.push_back('{2'b01, 32'hFFFFFFFE, 32'd3,        5'd4,  32'hFFFFFFFF});
    tbl.push_back('{2'b01, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000});
    tbl.push_back('{2'b10, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD});
    tbl.push_back('{2'b11, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF});
    tbl.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h80000000});
    tbl.push_back('{2'b11, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h00000000});
    tbl.push_back('{2'b10, 32'd9,        32'd0,        5'd10, 32'hFFFFFFFF});
    tbl.push_back('{2'b11, 32'hFFFFFFF7, 32'd0,        5'd11, 32'hFFFFFFF7});
    tbl.push_back('{2'b10, 32'd100,      32'hFFFFFFF9, 5'd12, 32'hFFFFFFF2});
    tbl.push_back('{2'b11, 32'd100,      32'hFFFFFFF9, 5'd13, 32'd2});
    tbl.push_back('{2'b00, 32'd2,        32'd2,        5'd0,  32'd4});
`else
    tbl.push_back('{2'b00, 32'd5,        32'd10,       5'd3,  32'd50});
    tbl.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE});
    tbl.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000001});
    tbl.push_back('{2'b10, 32'd100,      32'd7,        5'd4,  32'd14});
    tbl.push_back('{2'b11, 32'd100,      32'd7,        5'd5,  32'd2});
    tbl.push_back('{2'b10, 32'd9,        32'd0,        5'd6,  32'hFFFFFFFF});
    tbl.push_back('{2'b11, 32'd9,        32'd0,        5'd7,  32'd9});
    tbl.push_back('{2'b00, 32'd2,        32'd2,        5'd0,  32'd4});
    tbl.push_back('{2'b01, 32'h80000000, 32'd4,        5'd8,  32'd2});
    tbl.push_back('{2'b00, 32'h12345678, 32'h00000100, 5'd9,  32'h34567800});
    tbl.push_back('{2'b10, 32'hFFFFFFFF, 32'd1,        5'd10, 32'hFFFFFFFF});
    tbl.push_back('{2'b11, 32'hFFFFFFFF, 32'h10,       5'd11, 32'h0000000F});
    tbl.push_back('{2'b10, 32'd5,        32'd7,        5'd31, 32'd0});
`endif

    // Clock/reset block.
    repeat (3) @(negedge clk);
    check("reset ocupado", {31'd0, ocupado}, 32'd0);
    check("reset escrita", {31'd0, escrita}, 32'd0);
    check("reset destino", {27'd0, destino}, 32'd0);
    check("reset dado_saida", dado_saida, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].exp, 0, 0);

    run_op("ignore_5_32", 2'b00, 32'd3, 32'd4, 5'd5, 32'd12, 5, 32);
    run_op("ignore_escreve", 2'b00, 32'd6, 32'd7, 5'd6, 32'd42, 33, 0);

    // Reset in the middle of a divide aborts it.
    @(negedge clk);
    inicio = 1'b1; op = 2'b10; operando_a = 32'd100; operando_b = 32'd7; destino_in = 5'd4;
    @(negedge clk);
    inicio = 1'b0;
    repeat (9) @(negedge clk);
    check("abort busy_before", {31'd0, ocupado}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort ocupado", {31'd0, ocupado}, 32'd0);
    check("abort escrita", {31'd0, escrita}, 32'd0);
    check("abort destino", {27'd0, destino}, 32'd0);
    check("abort dado_saida", dado_saida, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int wr_n, busy_n;
      wr_n = 0; busy_n = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (escrita) wr_n++;
        if (ocupado) busy_n++;
      end
      check("abort writes_after", 32'(wr_n), 32'd0);
      check("abort busy_after", 32'(busy_n), 32'd0);
    end
    prev_data = '0;
    run_op("after_abort", 2'b10, 32'd100, 32'd7, 5'd4, 32'd14, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
